// File: rtl/quartz_countdown_ctrl_pkg.sv
// rtl/quartz_countdown_ctrl_pkg.sv - shared state encodings, defaults and BCD helper
//
// Purpose: definitions shared by the quartz countdown sequencer and its
//          display/flag neighbours.
//   qstate_t           : 2-bit sequencer state (IDLE, COUNT, EXPIRE, RELEASE)
//   DEF_TICKS_PER_SEC  : default SLOWCLOCK cycles per displayed second
//   DEF_START_SEC      : default countdown start value in seconds
//   DEF_ACK_TIMEOUT    : default EXPIRE wait for the clear acknowledge
//   to_bcd()           : integer 0..99 to packed {tens, ones} BCD
package quartz_countdown_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COUNT   = 2'd1,
      ST_EXPIRE  = 2'd2,
      ST_RELEASE = 2'd3
   } qstate_t;

   localparam int DEF_TICKS_PER_SEC = 10;
   localparam int DEF_START_SEC     = 15;
   localparam int DEF_ACK_TIMEOUT   = 4;

   function automatic logic [7:0] to_bcd(input int value);
      int v;
      v = value % 100;
      return {4'(v / 10), 4'(v % 10)};
   endfunction

endpackage

// File: rtl/quartz_countdown_ctrl_bcd2_down_counter.sv
// rtl/quartz_countdown_ctrl_bcd2_down_counter.sv - two-digit BCD down counter with load and zero flag
//
// Purpose: holds the remaining-seconds value shown on the display.
// Ports:
//   SLOWCLOCK  in  1  clock, posedge
//   RESET      in  1  synchronous active-high reset, loads RESET_BCD
//   load       in  1  load {load_tens, load_ones} (wins over dec)
//   load_tens  in  4  BCD tens to load
//   load_ones  in  4  BCD ones to load
//   dec        in  1  decrement by one second; ignored at 00
//   tens       out 4  BCD tens
//   ones       out 4  BCD ones
//   zero       out 1  1 when the value is 00
module bcd2_down_counter #(
   parameter logic [7:0] RESET_BCD = 8'h00
) (
   input  logic       SLOWCLOCK,
   input  logic       RESET,
   input  logic       load,
   input  logic [3:0] load_tens,
   input  logic [3:0] load_ones,
   input  logic       dec,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       zero
);

   assign zero = (tens == 4'd0) && (ones == 4'd0);

   always_ff @(posedge SLOWCLOCK) begin
      if (RESET) begin
         tens <= RESET_BCD[7:4];
         ones <= RESET_BCD[3:0];
      end else if (load) begin
         tens <= load_tens;
         ones <= load_ones;
      end else if (dec && !zero) begin
         // Saturate at 00 so the display can never underflow.
         if (ones == 4'd0) begin
            ones <= 4'd9;
            tens <= tens - 4'd1;
         end else begin
            ones <= ones - 4'd1;
         end
      end
   end

endmodule

// File: rtl/quartz_countdown_ctrl.sv
// rtl/quartz_countdown_ctrl.sv - quartz lock countdown and flag-clear handshake sequencer
//
// Purpose: once QUARTZ is set, counts START_SEC..0 seconds on SLOWCLOCK, shows the
//          remaining seconds in BCD, then clears the flag register with a
//          four-phase resetQUAR/resetFLAG handshake.
// Ports:
//   SLOWCLOCK  in  1  sole clock, posedge
//   RESET      in  1  synchronous active-high reset
//   QUARTZ     in  1  countdown request from the flag register
//   resetFLAG  in  1  clear acknowledge from the flag register
//   HOLD       in  1  freeze tick/seconds while counting
//   resetQUAR  out 1  clear request (registered)
//   sec_tens   out 4  BCD tens of remaining seconds
//   sec_ones   out 4  BCD ones of remaining seconds
//   busy       out 1  1 in COUNT, EXPIRE, RELEASE
//   expired    out 1  one-cycle pulse on EXPIRE entry
//   ack_err    out 1  sticky handshake timeout, cleared only by RESET
import quartz_countdown_ctrl_pkg::*;

module quartz_countdown_ctrl #(
   parameter int TICKS_PER_SEC = DEF_TICKS_PER_SEC,
   parameter int START_SEC     = DEF_START_SEC,
   parameter int ACK_TIMEOUT   = DEF_ACK_TIMEOUT
) (
   input  logic       SLOWCLOCK,
   input  logic       RESET,
   input  logic       QUARTZ,
   input  logic       resetFLAG,
   input  logic       HOLD,
   output logic       resetQUAR,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       busy,
   output logic       expired,
   output logic       ack_err
);

   generate
      if (START_SEC < 1 || START_SEC > 99) begin : g_bad_start_sec
         $error("START_SEC must be in 1..99");
      end
      if (TICKS_PER_SEC < 1) begin : g_bad_ticks
         $error("TICKS_PER_SEC must be >= 1");
      end
      if (ACK_TIMEOUT < 2) begin : g_bad_timeout
         $error("ACK_TIMEOUT must be >= 2");
      end
   endgenerate

   localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam int AW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS_PER_SEC - 1);
   localparam logic [AW-1:0] ACK_LAST   = AW'(ACK_TIMEOUT - 1);
   localparam logic [7:0]    START_BCD  = to_bcd(START_SEC);

   qstate_t       state, next_state;
   logic [TW-1:0] tick, tick_n;
   logic [AW-1:0] acnt, acnt_n;
   logic          ack_err_n;
   logic          sec_dec;
   logic          sec_load;
   logic          sec_zero;

   always_ff @(posedge SLOWCLOCK) begin
      if (RESET) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      tick_n     = tick;
      acnt_n     = acnt;
      ack_err_n  = ack_err;
      sec_dec    = 1'b0;
      case (state)
         ST_IDLE: begin
            tick_n = '0;
            acnt_n = '0;
            if (QUARTZ) begin
               next_state = ST_COUNT;
            end
         end
         ST_COUNT: begin
            acnt_n = '0;
            // An external clear of the flag aborts even while held.
            if (!QUARTZ) begin
               next_state = ST_IDLE;
               tick_n     = '0;
            end else if (!HOLD) begin
               if (tick == TICK_LAST) begin
                  tick_n = '0;
                  // 00 has been shown for a full second: countdown done.
                  if (sec_zero) begin
                     next_state = ST_EXPIRE;
                  end else begin
                     sec_dec = 1'b1;
                  end
               end else begin
                  tick_n = tick + TW'(1);
               end
            end
         end
         ST_EXPIRE: begin
            if (resetFLAG) begin
               next_state = ST_RELEASE;
            end else if (acnt == ACK_LAST) begin
               // Flag register never answered; give up and remember it.
               next_state = ST_IDLE;
               ack_err_n  = 1'b1;
            end else begin
               acnt_n = acnt + AW'(1);
            end
         end
         ST_RELEASE: begin
            if (!resetFLAG) begin
               next_state = ST_IDLE;
            end
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // Reloading on every edge that lands in IDLE makes the display show
   // START_SEC immediately after an abort, timeout or completed handshake.
   assign sec_load = (next_state == ST_IDLE);

   // Outputs are registered from the next state so they change on the
   // same edge as the state they describe.
   always_ff @(posedge SLOWCLOCK) begin
      if (RESET) begin
         tick      <= '0;
         acnt      <= '0;
         resetQUAR <= 1'b0;
         busy      <= 1'b0;
         expired   <= 1'b0;
         ack_err   <= 1'b0;
      end else begin
         tick      <= tick_n;
         acnt      <= acnt_n;
         resetQUAR <= (next_state == ST_EXPIRE);
         busy      <= (next_state != ST_IDLE);
         expired   <= (state == ST_COUNT) && (next_state == ST_EXPIRE);
         ack_err   <= ack_err_n;
      end
   end

   bcd2_down_counter #(
      .RESET_BCD (START_BCD)
   ) u_sec (
      .SLOWCLOCK (SLOWCLOCK),
      .RESET     (RESET),
      .load      (sec_load),
      .load_tens (START_BCD[7:4]),
      .load_ones (START_BCD[3:0]),
      .dec       (sec_dec),
      .tens      (sec_tens),
      .ones      (sec_ones),
      .zero      (sec_zero)
   );

endmodule

// File: tb/tb_quartz_countdown_ctrl.sv
// tb/tb_quartz_countdown_ctrl.sv - scoreboard bench for the quartz countdown sequencer
module tb_quartz_countdown_ctrl;

   localparam int T = 2;
   localparam int S = 3;
   localparam int A = 4;

   logic       SLOWCLOCK = 1'b0;
   logic       RESET     = 1'b1;
   logic       QUARTZ    = 1'b0;
   logic       resetFLAG = 1'b0;
   logic       HOLD      = 1'b0;
   logic       resetQUAR;
   logic [3:0] sec_tens;
   logic [3:0] sec_ones;
   logic       busy;
   logic       expired;
   logic       ack_err;
   logic       stuck     = 1'b0;

   always #5 SLOWCLOCK = ~SLOWCLOCK;

   quartz_countdown_ctrl #(
      .TICKS_PER_SEC (T),
      .START_SEC     (S),
      .ACK_TIMEOUT   (A)
   ) dut (
      .SLOWCLOCK (SLOWCLOCK),
      .RESET     (RESET),
      .QUARTZ    (QUARTZ),
      .resetFLAG (resetFLAG),
      .HOLD      (HOLD),
      .resetQUAR (resetQUAR),
      .sec_tens  (sec_tens),
      .sec_ones  (sec_ones),
      .busy      (busy),
      .expired   (expired),
      .ack_err   (ack_err)
   );

   // Flag register model: acknowledge follows the request one cycle later,
   // or never rises when stuck.
   always @(posedge SLOWCLOCK) begin
      if (RESET || stuck) resetFLAG <= 1'b0;
      else                resetFLAG <= resetQUAR;
   end

   typedef struct packed {
      logic       rq;
      logic       busy;
      logic       ex;
      logic       err;
      logic [3:0] t;
      logic [3:0] o;
   } obs_t;

   obs_t expq[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model: phase 0 idle, 1 counting, 2 awaiting ack, 3 awaiting release.
   // Counting is tracked as elapsed un-held cycles; seconds derive from it.
   int   ph = 0, e = 0, age = 0;
   bit   m_rq = 0, m_busy = 0, m_ex = 0, m_err = 0, m_flag = 0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
      end
   endtask

   task automatic model_step(input bit q, input bit h, input bit r);
      bit   fl_new;
      int   oph;
      int   sec;
      obs_t x;
      fl_new = (r || stuck) ? 1'b0 : m_rq;
      oph    = ph;
      if (r) begin
         ph = 0; e = 0; age = 0; m_err = 0;
      end else begin
         case (ph)
            0: if (q) begin ph = 1; e = 0; end
            1: begin
               if (!q) ph = 0;
               else if (!h) begin
                  e++;
                  if (e == (S + 1) * T) begin ph = 2; age = 0; end
               end
            end
            2: begin
               if (m_flag) ph = 3;
               else begin
                  age++;
                  if (age == A) begin ph = 0; m_err = 1; end
               end
            end
            default: if (!m_flag) ph = 0;
         endcase
      end
      m_rq   = (ph == 2);
      m_ex   = !r && (oph == 1) && (ph == 2);
      m_busy = (ph != 0);
      sec    = (ph == 0) ? S : (ph == 1) ? (S - e / T) : 0;
      m_flag = fl_new;
      x.rq   = m_rq;
      x.busy = m_busy;
      x.ex   = m_ex;
      x.err  = m_err;
      x.t    = 4'(sec / 10);
      x.o    = 4'(sec % 10);
      expq.push_back(x);
   endtask

   task automatic drive(input bit q, input bit h, input bit r, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge SLOWCLOCK);
         QUARTZ = q;
         HOLD   = h;
         RESET  = r;
         model_step(q, h, r);
      end
   endtask

   // Monitor: every edge presents a fresh output vector; compare it with
   // the prediction pushed when that edge's inputs were applied.
   initial begin
      obs_t o;
      forever begin
         @(posedge SLOWCLOCK);
         #2;
         if (expq.size() > 0) begin
            o = expq.pop_front();
            chk("resetQUAR", {7'd0, resetQUAR}, {7'd0, o.rq});
            chk("busy",      {7'd0, busy},      {7'd0, o.busy});
            chk("expired",   {7'd0, expired},   {7'd0, o.ex});
            chk("ack_err",   {7'd0, ack_err},   {7'd0, o.err});
            chk("sec_tens",  {4'd0, sec_tens},  {4'd0, o.t});
            chk("sec_ones",  {4'd0, sec_ones},  {4'd0, o.o});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // 1: reset
      drive(0, 0, 1, 2);
      drive(0, 0, 0, 2);
      // 2: normal countdown and handshake
      drive(1, 0, 0, 10);
      drive(0, 0, 0, 8);
      // 3: HOLD for 5 cycles while showing 02
      drive(1, 0, 0, 3);
      drive(1, 1, 0, 5);
      drive(1, 0, 0, 14);
      drive(0, 0, 0, 6);
      // 4: external clear while showing 01
      drive(1, 0, 0, 6);
      drive(0, 0, 0, 4);
      // 5: acknowledge never returns, then a normal run keeps ack_err
      stuck = 1'b1;
      drive(1, 0, 0, 14);
      drive(0, 0, 0, 3);
      stuck = 1'b0;
      drive(1, 0, 0, 10);
      drive(0, 0, 0, 8);
      drive(0, 0, 1, 1);
      drive(0, 0, 0, 2);
      // 6: reset while in EXPIRE
      drive(1, 0, 0, 10);
      drive(1, 0, 1, 1);
      drive(0, 0, 0, 3);
      // random traffic
      for (int i = 0; i < 700; i++) begin
         if (i % 40 == 0) stuck = ($urandom_range(0, 3) == 0);
         drive(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 99) == 0), 1);
      end
      stuck = 1'b0;
      drive(0, 0, 0, 2);
      @(posedge SLOWCLOCK);
      #3;
      chk("queue_drained", 8'(expq.size()), 8'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
